// File: rtl/bf_decrypt_core_pkg.sv
// bf_pkg: shared types and constants for the Blowfish block core.
//   bf_state_t : FSM states (IDLE, RA, RB, F1, F2, DONE)
//   bf_half_t  : 32-bit half block
//   N_ROUNDS / P_WORDS / P_LAST / BF_LATENCY : algorithm and timing constants
package bf_pkg;

   localparam int WIDTH      = 32;
   localparam int N_ROUNDS   = 16;
   localparam int P_WORDS    = 18;
   localparam int P_LAST     = 17;
   // Cycles from the accepting edge until out_valid is visible:
   // 32 round cycles + F1 + F2 + the first DONE cycle.
   localparam int BF_LATENCY = 35;

   typedef logic [WIDTH-1:0] bf_half_t;

   typedef enum logic [2:0] {
      IDLE,
      RA,
      RB,
      F1,
      F2,
      DONE
   } bf_state_t;

endpackage

// File: rtl/bf_decrypt_core_if.sv
// bf_decrypt_core_if: block stream handshake plus the read ports of the
// external P-array / S-box RAMs.
//   in_valid/in_ready/in_block    : ciphertext input ([63:32]=xL, [31:0]=xR)
//   out_valid/out_ready/out_block : plaintext output
//   p_addr/p_rdata                : P-array read, data one cycle after address
//   sbox_addr[k]/sbox_data[k]     : S-box k read, data one cycle after address
//   mode (BF_ENCRYPT_EN builds)   : 1=encrypt, 0=decrypt, sampled with in_block
// master = environment (block source/sink and RAM owner), slave = the core.
interface bf_decrypt_core_if;
   import bf_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [63:0]     in_block;
   logic            out_valid;
   logic            out_ready;
   logic [63:0]     out_block;
   logic [4:0]      p_addr;
   bf_half_t        p_rdata;
   logic [3:0][7:0] sbox_addr;
   logic [3:0][31:0] sbox_data;
`ifdef BF_ENCRYPT_EN
   logic            mode;
`endif

   modport master (
      output in_valid, in_block, out_ready, p_rdata, sbox_data,
`ifdef BF_ENCRYPT_EN
      output mode,
`endif
      input  in_ready, out_valid, out_block, p_addr, sbox_addr
   );

   modport slave (
      input  in_valid, in_block, out_ready, p_rdata, sbox_data,
`ifdef BF_ENCRYPT_EN
      input  mode,
`endif
      output in_ready, out_valid, out_block, p_addr, sbox_addr
   );

endinterface

// File: rtl/bf_decrypt_core_feistel.sv
// bf_feistel_f: Blowfish round function, purely combinational.
//   s0..s3 : S-box words S0[a], S1[b], S2[c], S3[d]
//   f      : ((s0 + s1) ^ s2) + s3, additions modulo 2^32
module bf_feistel_f
   import bf_pkg::*;
(
   input  bf_half_t s0,
   input  bf_half_t s1,
   input  bf_half_t s2,
   input  bf_half_t s3,
   output bf_half_t f
);

   bf_half_t sum01;
   bf_half_t mix;

   assign sum01 = s0 + s1;
   assign mix   = sum01 ^ s2;
   assign f     = mix + s3;

endmodule

// File: rtl/bf_decrypt_core.sv
// bf_decrypt_core: iterative Blowfish block decryptor (16 Feistel rounds,
// P-array applied P17 down to P0). P-array and S-boxes are external
// synchronous RAMs; this core only drives their read addresses.
//   clk     : clock
//   reset_l : asynchronous active-low reset
//   bus     : bf_decrypt_core_if.slave (block handshake + RAM read ports)
// Optional macro BF_ENCRYPT_EN adds bus.mode: 1 selects the ascending
// (encrypt) P order 0..17, 0 keeps decryption.
// Each round takes two cycles: RA folds in P and issues the S-box reads,
// RB consumes the S-box data and swaps halves.
module bf_decrypt_core
   import bf_pkg::*;
(
   input  logic             clk,
   input  logic             reset_l,
   bf_decrypt_core_if.slave bus
);

   bf_state_t       state_reg;
   bf_half_t        xl_reg;
   bf_half_t        xr_reg;
   logic [4:0]      idx_reg;
   logic            in_ready_reg;
   logic            out_valid_reg;
   logic [63:0]     out_block_reg;
`ifdef BF_ENCRYPT_EN
   logic            enc_reg;
`endif

   bf_half_t        t_val;
   bf_half_t        f_val;
   logic [4:0]      idx_next;
   logic            last_round;
   logic [4:0]      p_addr_sel;
   logic [3:0][7:0] sbox_addr_sel;

   // P word arriving this cycle folded into the left half (valid in RA).
   assign t_val = xl_reg ^ bus.p_rdata;

   // S-box k is addressed by byte k of t, byte 0 being the most significant.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sbox_addr
         assign sbox_addr_sel[gi] = (state_reg == RA) ? t_val[31-8*gi -: 8] : 8'h00;
      end
   endgenerate

   bf_feistel_f u_feistel (
      .s0 (bus.sbox_data[0]),
      .s1 (bus.sbox_data[1]),
      .s2 (bus.sbox_data[2]),
      .s3 (bus.sbox_data[3]),
      .f  (f_val)
   );

`ifdef BF_ENCRYPT_EN
   assign idx_next   = enc_reg ? (idx_reg + 5'd1) : (idx_reg - 5'd1);
   assign last_round = enc_reg ? (idx_next == 5'(N_ROUNDS)) : (idx_next == 5'd1);
`else
   assign idx_next   = idx_reg - 5'd1;
   assign last_round = (idx_next == 5'd1);
`endif

   // The RAM read is one cycle deep, so every state addresses the word the
   // following state consumes: IDLE->first RA, RB->next RA, F1->F2.
   always_comb begin
      p_addr_sel = 5'(P_LAST);
      case (state_reg)
         IDLE: begin
`ifdef BF_ENCRYPT_EN
            p_addr_sel = bus.mode ? 5'd0 : 5'(P_LAST);
`else
            p_addr_sel = 5'(P_LAST);
`endif
         end
         RA: p_addr_sel = idx_reg;
         RB: p_addr_sel = idx_next;
         F1: begin
`ifdef BF_ENCRYPT_EN
            p_addr_sel = enc_reg ? 5'(P_LAST) : 5'd0;
`else
            p_addr_sel = 5'd0;
`endif
         end
         default: p_addr_sel = 5'(P_LAST);
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         state_reg     <= IDLE;
         xl_reg        <= '0;
         xr_reg        <= '0;
         idx_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_block_reg <= '0;
`ifdef BF_ENCRYPT_EN
         enc_reg       <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.in_valid) begin
                  xl_reg       <= bus.in_block[63:32];
                  xr_reg       <= bus.in_block[31:0];
`ifdef BF_ENCRYPT_EN
                  enc_reg      <= bus.mode;
                  idx_reg      <= bus.mode ? 5'd0 : 5'(P_LAST);
`else
                  idx_reg      <= 5'(P_LAST);
`endif
                  in_ready_reg <= 1'b0;
                  state_reg    <= RA;
               end
            end
            RA: begin
               xl_reg    <= t_val;
               state_reg <= RB;
            end
            RB: begin
               xl_reg    <= xr_reg ^ f_val;
               xr_reg    <= xl_reg;
               idx_reg   <= idx_next;
               state_reg <= last_round ? F1 : RA;
            end
            F1: begin
               // undo the last round's swap and fold in the second-to-last P
               xl_reg    <= xr_reg;
               xr_reg    <= xl_reg ^ bus.p_rdata;
               state_reg <= F2;
            end
            F2: begin
               xl_reg        <= xl_reg ^ bus.p_rdata;
               out_block_reg <= {xl_reg ^ bus.p_rdata, xr_reg};
               out_valid_reg <= 1'b1;
               state_reg     <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_block = out_block_reg;
   assign bus.p_addr    = p_addr_sel;
   assign bus.sbox_addr = sbox_addr_sel;

endmodule

// File: tb/tb_bf_decrypt_core.sv
// Testbench for bf_decrypt_core. The bench owns the P/S RAMs and loads one of
// three key schedules: all zero (rounds reduce to swaps), P[i]=1<<i with zero
// S-boxes (XOR-only, hand-computable), and a mixed schedule checked by
// decrypting blocks produced by a textbook Blowfish encrypt model.
module tb_bf_decrypt_core;
   import bf_pkg::*;

   logic clk = 1'b0;
   logic reset_l;

   bf_decrypt_core_if bus();

   bf_decrypt_core dut (
      .clk     (clk),
      .reset_l (reset_l),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // External key-schedule RAMs, one-cycle registered read.
   logic [31:0] p_mem [P_WORDS];
   logic [31:0] s_mem [4][256];

   always @(posedge clk) begin
      bus.p_rdata <= p_mem[bus.p_addr];
      for (int k = 0; k < 4; k++)
         bus.sbox_data[k] <= s_mem[k][bus.sbox_addr[k]];
   end

`ifdef BF_ENCRYPT_EN
   logic tb_mode = 1'b0;
   assign bus.mode = tb_mode;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [4:0] trace [40];

   typedef struct {
      string       name;
      int          sched;
      logic [63:0] blk;
      logic [63:0] exp;
      bit          rt;        // blk = model encrypt(exp)
      int          hold;      // cycles of out_ready=0 after out_valid
      bit          trace_chk;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end else begin
         $display("pass %s: %h", name, got);
      end
   endtask

   function automatic logic [31:0] mix32(input int k, input int x);
      logic [31:0] w;
      w = (32'(x + 1) * 32'h01000193) ^ (32'(k + 1) * 32'h7F4A7C15);
      return w ^ (w >> 13) ^ (w << 7);
   endfunction

   task automatic load_sched(input int s);
      for (int i = 0; i < P_WORDS; i++)
         p_mem[i] = (s == 1) ? (32'd1 << i) :
                    (s == 2) ? (32'h243F6A88 ^ (32'h9E3779B9 * 32'(i + 1))) : 32'd0;
      for (int k = 0; k < 4; k++)
         for (int x = 0; x < 256; x++)
            s_mem[k][x] = (s == 2) ? mix32(k, x) : 32'd0;
   endtask

   function automatic logic [31:0] ref_f(input logic [31:0] x);
      return ((s_mem[0][x[31:24]] + s_mem[1][x[23:16]]) ^ s_mem[2][x[15:8]]) + s_mem[3][x[7:0]];
   endfunction

   // Textbook Blowfish encryption with the currently loaded schedule.
   function automatic logic [63:0] ref_encrypt(input logic [63:0] pt);
      logic [31:0] l, r, tmp;
      l = pt[63:32];
      r = pt[31:0];
      for (int i = 0; i < 16; i++) begin
         l   = l ^ p_mem[i];
         r   = r ^ ref_f(l);
         tmp = l; l = r; r = tmp;
      end
      tmp = l; l = r; r = tmp;
      r = r ^ p_mem[16];
      l = l ^ p_mem[17];
      return {l, r};
   endfunction

   // Offer a block; returns at the negedge of the first cycle after accept.
   task automatic start(input logic [63:0] blk);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) chk("start_in_ready_timeout", 64'd0, 64'd1);
      bus.in_block = blk;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic finish_block(input string name, input logic [63:0] exp, input int hold);
      int cnt;
      bit ready_bad;
      bit stable;
      logic [63:0] held;
      cnt = 1;
      ready_bad = 1'b0;
      while (!bus.out_valid && cnt < 100) begin
         if (bus.in_ready) ready_bad = 1'b1;
         if (cnt < 40) trace[cnt] = bus.p_addr;
         @(negedge clk);
         cnt++;
      end
      if (bus.in_ready) ready_bad = 1'b1;
      chk({name, "_latency"}, 64'(cnt), 64'(BF_LATENCY));
      chk({name, "_out_block"}, bus.out_block, exp);
      chk({name, "_in_ready_low_while_busy"}, 64'(ready_bad), 64'd0);
      if (hold > 0) begin
         held = bus.out_block;
         stable = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_block !== held || bus.in_ready) stable = 1'b0;
         end
         chk({name, "_backpressure_stable"}, 64'(stable), 64'd1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({name, "_idle_after_accept_{ov,ir}"}, 64'({bus.out_valid, bus.in_ready}), 64'b01);
   endtask

   task automatic check_trace();
      int c;
      int bad;
      c = 1;
      bad = 0;
      for (int i = 17; i >= 2; i--) begin
         if (trace[c] !== 5'(i)) bad++;
         c++;
         if (trace[c] !== 5'(i - 1)) bad++;
         c++;
      end
      if (trace[c] !== 5'd0) bad++;
      chk("p_addr_trace_bad_entries", 64'(bad), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] blk, a, b, pt1, pt2, pt3;
      int cyc;
      bit both_high;
      int acc_q[$];
      logic [63:0] res_q[$];

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_block  = '0;
      reset_l       = 1'b0;
      load_sched(0);
      repeat (3) @(negedge clk);

      chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset_out_block", bus.out_block, 64'd0);
      chk("reset_p_addr", 64'(bus.p_addr), 64'd17);
      chk("reset_sbox_addr", 64'(bus.sbox_addr), 64'd0);
      reset_l = 1'b1;

      // out = {R ^ (P16^P14^..^P0), L ^ (P17^P15^..^P1)} when F == 0
      vecs[0] = '{"zero_sched_a", 0, 64'h0123456789ABCDEF, 64'h89ABCDEF01234567, 1'b0, 0, 1'b0};
      vecs[1] = '{"zero_sched_b", 0, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b0, 0, 1'b0};
      vecs[2] = '{"pshift_zero_blk", 1, 64'h0000000000000000, 64'h000155550002AAAA, 1'b0, 0, 1'b0};
      vecs[3] = '{"pshift_trace", 1, 64'hDEADBEEFCAFEF00D, 64'hCAFFA558DEAF1445, 1'b0, 0, 1'b1};
      vecs[4] = '{"mixed_rt_hold", 2, 64'd0, 64'h0123456789ABCDEF, 1'b1, 20, 1'b0};
      vecs[5] = '{"mixed_rt_zero", 2, 64'd0, 64'h0000000000000000, 1'b1, 0, 1'b0};

      for (int i = 0; i < 6; i++) begin
         load_sched(vecs[i].sched);
         blk = vecs[i].rt ? ref_encrypt(vecs[i].exp) : vecs[i].blk;
         start(blk);
         finish_block(vecs[i].name, vecs[i].exp, vecs[i].hold);
         if (vecs[i].trace_chk) check_trace();
      end

      // in_valid held high across two blocks with out_ready always high
      pt1 = 64'hA5A5A5A55A5A5A5A;
      pt2 = 64'h1122334455667788;
      a = ref_encrypt(pt1);
      b = ref_encrypt(pt2);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_block = a;
      bus.in_valid = 1'b1;
      cyc = 0;
      both_high = 1'b0;
      if (bus.in_ready) acc_q.push_back(0);
      while (res_q.size() < 2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         bus.in_block = b;
         if (bus.in_ready && bus.out_valid) both_high = 1'b1;
         if (bus.in_ready) acc_q.push_back(cyc);
         if (bus.out_valid) res_q.push_back(bus.out_block);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("b2b_accept_count", 64'(acc_q.size()), 64'd2);
      chk("b2b_spacing", (acc_q.size() >= 2) ? 64'(acc_q[1] - acc_q[0]) : 64'hFFFF, 64'd36);
      chk("b2b_result_a", (res_q.size() >= 1) ? res_q[0] : 64'hX, pt1);
      chk("b2b_result_b", (res_q.size() >= 2) ? res_q[1] : 64'hX, pt2);
      chk("b2b_valid_ready_exclusive", 64'(both_high), 64'd0);

      // asynchronous reset in cycle 10 of a block
      pt3 = 64'h0F1E2D3C4B5A6978;
      start(ref_encrypt(pt3));
      repeat (9) @(negedge clk);
      reset_l = 1'b0;
      #1;
      chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
      chk("midreset_in_ready", 64'(bus.in_ready), 64'd1);
      chk("midreset_out_block", bus.out_block, 64'd0);
      chk("midreset_p_addr", 64'(bus.p_addr), 64'd17);
      @(negedge clk);
      reset_l = 1'b1;
      start(ref_encrypt(pt3));
      finish_block("after_reset", pt3, 0);

`ifdef BF_ENCRYPT_EN
      load_sched(2);
      tb_mode = 1'b1;
      start(64'd0);
      tb_mode = 1'b0;
      finish_block("encrypt_zero", ref_encrypt(64'd0), 0);
      start(ref_encrypt(64'd0));
      finish_block("decrypt_roundtrip", 64'd0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bf_decrypt_core.md
Name: bf_decrypt_core

Overview:
- Iterative Blowfish block decryptor: 64-bit ciphertext in, 64-bit plaintext out. It is the inverse direction of the bcrypt Blowfish encrypt path.
- Runs 16 Feistel rounds with the P-array applied in reverse order (P17 down to P0).
- P-array and S-boxes live in external synchronous RAMs owned by the key-schedule logic; this block only reads them.
- Valid/ready handshake on both the input and output sides.

Parameters:
- N_ROUNDS, 16, Feistel rounds; fixed by the algorithm, only 16 is supported.
- WIDTH, 32, half-block width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset_l  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext offered
- in_ready  out  1  core idle, can accept
- in_block  in  64  ciphertext; [63:32]=xL, [31:0]=xR
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts
- out_block  out  64  plaintext; [63:32]=xL, [31:0]=xR
- p_addr  out  5  P-array read address, 0..17
- p_rdata  in  32  P word for the p_addr driven in the previous cycle
- sbox_addr0..3  out  8 each  S0..S3 read addresses
- sbox_data0..3  in  32 each  S0..S3 data for the addresses driven in the previous cycle

Behaviour:
- Reset: all state cleared; state=IDLE, in_ready=1, out_valid=0, out_block=0, p_addr=17, sbox_addr*=0.
- Reset is asynchronous; asserting it mid-operation aborts the block and no output is produced.
- States:
  - IDLE: in_ready=1, p_addr=17. On in_valid: latch xL/xR, set idx=17, go to RA.
  - RA (round A): t = xL ^ p_rdata. Drive sbox_addrK = t byte K, with byte 0 = t[31:24]. Register xL<=t. p_addr=idx. Go to RB.
  - RB (round B): F = ((sbox_data0 + sbox_data1) ^ sbox_data2) + sbox_data3, additions mod 2^32.
    - Update xL<=xR^F, xR<=xL (swap). p_addr=idx-1, then idx<=idx-1.
    - If the new idx==1, go to F1; else go to RA.
  - F1 (final 1): undo the last swap and fold in P1: xL<=xR, xR<=xL^p_rdata (p_rdata=P1). p_addr=0. Go to F2.
  - F2 (final 2): xL<=xL^p_rdata (p_rdata=P0). Go to DONE.
  - DONE: out_valid=1, out_block={xL,xR}. Hold stable until out_ready. Then out_valid falls and the core returns to IDLE in the next cycle.
- Every P/S read is a 1-cycle synchronous read. p_addr is driven combinationally from state and idx so that each consuming state sees the word it needs.
- Latency: 35 cycles from the in_valid&in_ready edge to out_valid (32 round cycles + F1 + F2 + 1).
- Throughput: one block per 36 cycles minimum.
- in_ready=0 in every state except IDLE; in_valid outside IDLE is ignored.
- out_valid and in_ready are never high simultaneously.
- in_valid may rise in the same cycle that out_ready is accepted; it is honoured only from IDLE, one cycle later.
- idx never wraps; a value outside 1..17 in RA/RB is unreachable.

Optional Feature:
- Macro: BF_ENCRYPT_EN.
- Defined:
  - Adds port mode (in, 1), sampled with in_block; 1=encrypt, 0=decrypt.
  - Encrypt sequence: idx starts at 0 and increments; p_addr order is 0..15 in rounds, then 16 in F1 and 17 in F2.
  - Latency and handshake are identical to decrypt.
- Undefined: no mode port; decrypt only; logic for the ascending sequence is absent.

Decomposition:
- Package bf_pkg holds:
  - state enum {IDLE,RA,RB,F1,F2,DONE}
  - constants N_ROUNDS=16, P_WORDS=18, P_LAST=17, BF_LATENCY=35
  - typedef bf_half_t = logic [31:0]
- One sub-module: bf_feistel_f, combinational: four 32-bit S-box data inputs to F. It is built from the existing adder and xorer cells.

Test Plan:
- All-zero key schedule loaded by the bench model; in_block=64'h4EF997456198DD78 -> out_block=64'h0000000000000000 exactly 35 cycles after accept.
- Key FFFFFFFFFFFFFFFF schedule; in_block=64'h51866FD5B85ECB8A -> out_block=64'hFFFFFFFFFFFFFFFF. Also check the p_addr trace: 17,17,16,16,15,...,2,1,0.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and out_block stable, in_ready=0 throughout. Pulse out_ready -> IDLE next cycle.
- in_valid held high across a whole operation -> second block accepted only from IDLE; back-to-back spacing is 36 cycles; both results correct.
- Assert reset_l low during cycle 10 of a block -> immediate out_valid=0, in_ready=1, out_block=0. The next block decrypts correctly.
- BF_ENCRYPT_EN build, mode=1, all-zero key, in_block=0 -> out_block=64'h4EF997456198DD78. Then mode=0 round-trips it back to 0.
